// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between two pipeline stages: an upstream channel
// (in_*) feeding the stage and a downstream channel (out_*) leaving it.
// The stage register takes the slave view; the surrounding logic (or a
// bench) takes the master view, driving payload in and ready out.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int SIDE_W = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [SIDE_W-1:0] in_side;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [SIDE_W-1:0] out_side;

    modport master (
        output in_valid, in_data, in_side, out_ready,
        input  in_ready, out_valid, out_data, out_side
    );

    modport slave (
        input  in_valid, in_data, in_side, out_ready,
        output in_ready, out_valid, out_data, out_side
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with a 2-entry skid buffer. The main register
// drives the downstream outputs directly; the skid register catches the one
// word that can arrive in the cycle after downstream stalls, which lets
// in_ready be a flop instead of a combinational path from out_ready.
// Flush squashes both entries to a bubble. Two saturating counters record
// stall and starve cycles for performance debug.
module pipe_stage_reg #(
    parameter int                DATA_W       = 32,
    parameter int                SIDE_W       = 2,
    parameter logic [DATA_W-1:0] BUBBLE_VALUE = '0,
    parameter int                CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    pipe_stage_reg_if.slave      bus,
    output logic [1:0]           occupancy,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     starve_cnt
);

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic [SIDE_W-1:0] main_side;
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic [SIDE_W-1:0] skid_side;
    logic              ready_q;
    logic              in_fire;
    logic              out_fire;

    assign in_fire  = bus.in_valid & ready_q;
    assign out_fire = main_valid & bus.out_ready;

    assign bus.in_ready  = ready_q;
    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_data;
    assign bus.out_side  = main_side;
    assign occupancy     = {1'b0, main_valid} + {1'b0, skid_valid};

    // Payload storage: main register advances when it is empty or being
    // consumed (skid first, to keep FIFO order); otherwise new input parks
    // in the skid register and in_ready drops for the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            main_data  <= BUBBLE_VALUE;
            main_side  <= '0;
            skid_valid <= 1'b0;
            skid_data  <= BUBBLE_VALUE;
            skid_side  <= '0;
            ready_q    <= 1'b1;
        end else if (flush) begin
            main_valid <= 1'b0;
            main_data  <= BUBBLE_VALUE;
            main_side  <= '0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
        end else if (!main_valid || out_fire) begin
            if (skid_valid) begin
                main_valid <= 1'b1;
                main_data  <= skid_data;
                main_side  <= skid_side;
                skid_valid <= 1'b0;
                ready_q    <= 1'b1;
            end else if (in_fire) begin
                main_valid <= 1'b1;
                main_data  <= bus.in_data;
                main_side  <= bus.in_side;
            end else begin
                main_valid <= 1'b0;
                main_data  <= BUBBLE_VALUE;
                main_side  <= '0;
            end
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_data  <= bus.in_data;
            skid_side  <= bus.in_side;
            ready_q    <= 1'b0;
        end
    end

    // Performance counters: qualified on the pre-update handshake state, so
    // a flush cycle is counted like any other cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt  <= '0;
            starve_cnt <= '0;
        end else begin
            if (main_valid && !bus.out_ready) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (!main_valid && bus.out_ready) begin
                starve_cnt <= sat_inc(starve_cnt);
            end
        end
    end

endmodule
